// File: rtl/lc3_mar_unit.sv
// lc3_mar_unit
//   Memory-address path for an LC-3 style datapath. A four-way source mux
//   picks the next address, the MAR captures it, and a small FSM runs one
//   request/acknowledge memory access at a time, with a timeout on the ack.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no access; MAR may load; i_start launches an access
//   REQ   | o_mem_req high, waiting for i_mem_ack, timeout counter runs
//   DONE  | one-cycle o_done pulse after ack, returns to IDLE
//   ERR   | one-cycle o_err pulse after timeout, MAR keeps faulting addr
//
// Ports
//   i_clk, i_rst_n   clock (rising edge), async active-low reset
//   i_sel            0 SEXT(imm), 1 offset addr, 2 ZEXT(imm), 3 reg addr
//   i_imm            IR immediate field
//   i_offset_addr    base+offset adder result
//   i_reg_addr       register operand used as an address
//   i_ld_mar         load MAR from the mux (IDLE only)
//   i_start, i_we    launch an access (IDLE only), access type
//   i_mem_ack        memory completion (REQ only)
//   o_addr_next      combinational mux output
//   o_mar            MAR contents
//   o_mem_req        request, held until ack or timeout
//   o_mem_we         registered access type
//   o_busy           high outside IDLE
//   o_done, o_err    one-cycle completion / timeout pulses
module lc3_mar_unit #(
    parameter int ADDR_W  = 16,
    parameter int IMM_W   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [1:0]        i_sel,
    input  logic [IMM_W-1:0]  i_imm,
    input  logic [ADDR_W-1:0] i_offset_addr,
    input  logic [ADDR_W-1:0] i_reg_addr,
    input  logic              i_ld_mar,
    input  logic              i_start,
    input  logic              i_we,
    input  logic              i_mem_ack,
    output logic [ADDR_W-1:0] o_addr_next,
    output logic [ADDR_W-1:0] o_mar,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    // Counter is sized for the largest legal TIMEOUT (255).
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] tmo_cnt;

    always_comb begin
        o_addr_next = '0;
        case (i_sel)
            2'd0:    o_addr_next = {{(ADDR_W-IMM_W){i_imm[IMM_W-1]}}, i_imm};
            2'd1:    o_addr_next = i_offset_addr;
            2'd2:    o_addr_next = {{(ADDR_W-IMM_W){1'b0}}, i_imm};
            default: o_addr_next = i_reg_addr;
        endcase
    end

    assign o_busy = (state != IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            o_mar     <= '0;
            o_mem_req <= 1'b0;
            o_mem_we  <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            // Pulses are raised only on the transition into DONE/ERR.
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_ld_mar) begin
                        o_mar <= o_addr_next;
                    end
                    if (i_start) begin
                        state     <= REQ;
                        o_mem_req <= 1'b1;
                        o_mem_we  <= i_we;
                        tmo_cnt   <= '0;
                    end
                end
                REQ: begin
                    // Ack takes priority over a timeout in the same cycle.
                    if (i_mem_ack) begin
                        state     <= DONE;
                        o_mem_req <= 1'b0;
                        o_done    <= 1'b1;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state     <= ERR;
                        o_mem_req <= 1'b0;
                        o_err     <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                DONE: state <= IDLE;
                ERR:  state <= IDLE;
                default: begin
                    state     <= IDLE;
                    o_mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_mar_unit.sv
module tb_lc3_mar_unit;

    logic        clk;
    logic        rst_n;
    logic [1:0]  sel;
    logic [7:0]  imm;
    logic [8:0]  imm_w;
    logic [15:0] offset_addr;
    logic [15:0] reg_addr;
    logic [19:0] offset_w;
    logic [19:0] reg_w;
    logic        ld_mar;
    logic        start;
    logic        we;
    logic        ack;

    // u_a: TIMEOUT=4 ; u_b: all defaults ; u_w: ADDR_W=20, IMM_W=9
    logic [15:0] addr_a, mar_a, addr_b, mar_b;
    logic [19:0] addr_w, mar_w;
    logic req_a, we_a, busy_a, done_a, err_a;
    logic req_b, we_b, busy_b, done_b, err_b;
    logic req_w, we_w, busy_w, done_w, err_w;

    int n_cmp = 0;
    int n_bad = 0;

    lc3_mar_unit #(.ADDR_W(16), .IMM_W(8), .TIMEOUT(4)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_sel(sel), .i_imm(imm),
        .i_offset_addr(offset_addr), .i_reg_addr(reg_addr),
        .i_ld_mar(ld_mar), .i_start(start), .i_we(we), .i_mem_ack(ack),
        .o_addr_next(addr_a), .o_mar(mar_a), .o_mem_req(req_a),
        .o_mem_we(we_a), .o_busy(busy_a), .o_done(done_a), .o_err(err_a)
    );

    lc3_mar_unit u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_sel(sel), .i_imm(imm),
        .i_offset_addr(offset_addr), .i_reg_addr(reg_addr),
        .i_ld_mar(ld_mar), .i_start(start), .i_we(we), .i_mem_ack(ack),
        .o_addr_next(addr_b), .o_mar(mar_b), .o_mem_req(req_b),
        .o_mem_we(we_b), .o_busy(busy_b), .o_done(done_b), .o_err(err_b)
    );

    lc3_mar_unit #(.ADDR_W(20), .IMM_W(9), .TIMEOUT(15)) u_w (
        .i_clk(clk), .i_rst_n(rst_n), .i_sel(sel), .i_imm(imm_w),
        .i_offset_addr(offset_w), .i_reg_addr(reg_w),
        .i_ld_mar(ld_mar), .i_start(start), .i_we(we), .i_mem_ack(ack),
        .o_addr_next(addr_w), .o_mar(mar_w), .o_mem_req(req_w),
        .o_mem_we(we_w), .o_busy(busy_w), .o_done(done_w), .o_err(err_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse i_start, then track both 16-bit instances until they are idle.
    // ack_at = index of the u_a req cycle on which ack is driven (0 = never).
    task automatic run_access(input int ack_at, input logic we_v,
                              output int nreq_a, output int ndone_a, output int nerr_a,
                              output int nreq_b, output int ndone_b, output int nerr_b,
                              output bit expired);
        nreq_a = 0; ndone_a = 0; nerr_a = 0;
        nreq_b = 0; ndone_b = 0; nerr_b = 0;
        expired = 1'b1;
        start = 1'b1;
        we    = we_v;
        step();
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (req_a)  nreq_a++;
            if (req_b)  nreq_b++;
            if (done_a) ndone_a++;
            if (err_a)  nerr_a++;
            if (done_b) ndone_b++;
            if (err_b)  nerr_b++;
            ack = (ack_at != 0) && req_a && (nreq_a == ack_at);
            if (!busy_a && !busy_b) begin
                expired = 1'b0;
                break;
            end
            step();
        end
        ack = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [7:0]  imm;
        logic [8:0]  imm_w;
        logic [15:0] offset;
        logic [15:0] regv;
        logic [15:0] exp;
        logic [19:0] exp_w;
    } mux_vec_t;

    mux_vec_t vecs[7];

    int  ra, da, ea, rb, db, eb;
    bit  exp_flag;

    initial begin
        vecs[0] = '{2'd0, 8'hF0, 9'h100, 16'h3005, 16'h4000, 16'hFFF0, 20'hFFF00};
        vecs[1] = '{2'd2, 8'hF0, 9'h100, 16'h3005, 16'h4000, 16'h00F0, 20'h00100};
        vecs[2] = '{2'd1, 8'hF0, 9'h100, 16'h3005, 16'h4000, 16'h3005, 20'h53005};
        vecs[3] = '{2'd3, 8'hF0, 9'h100, 16'h3005, 16'h4000, 16'h4000, 20'hF4000};
        vecs[4] = '{2'd0, 8'h7F, 9'h0FF, 16'h3005, 16'h4000, 16'h007F, 20'h000FF};
        vecs[5] = '{2'd2, 8'h80, 9'h1FF, 16'h3005, 16'h4000, 16'h0080, 20'h001FF};
        vecs[6] = '{2'd0, 8'h80, 9'h0FF, 16'h3005, 16'h4000, 16'hFF80, 20'h000FF};

        rst_n = 1'b0; sel = 2'd0; imm = '0; imm_w = '0;
        offset_addr = '0; reg_addr = '0;
        offset_w = 20'h53005; reg_w = 20'hF4000;
        ld_mar = 1'b0; start = 1'b0; we = 1'b0; ack = 1'b0;

        #3;
        check("rst_mar",  {16'h0, mar_a}, 32'h0);
        check("rst_req",  {31'h0, req_a}, 32'h0);
        check("rst_we",   {31'h0, we_a}, 32'h0);
        check("rst_busy", {31'h0, busy_a}, 32'h0);
        check("rst_done", {31'h0, done_a}, 32'h0);
        check("rst_err",  {31'h0, err_a}, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // Source mux, all three parameterisations
        for (int i = 0; i < 7; i++) begin
            sel = vecs[i].sel; imm = vecs[i].imm; imm_w = vecs[i].imm_w;
            offset_addr = vecs[i].offset; reg_addr = vecs[i].regv;
            #1;
            check($sformatf("mux_a[%0d]", i), {16'h0, addr_a}, {16'h0, vecs[i].exp});
            check($sformatf("mux_b[%0d]", i), {16'h0, addr_b}, {16'h0, vecs[i].exp});
            check($sformatf("mux_w[%0d]", i), {12'h0, addr_w}, {12'h0, vecs[i].exp_w});
        end
        step();

        // Load + start in the same cycle, read, ack on the 2nd req cycle
        sel = 2'd1; offset_addr = 16'h3010; ld_mar = 1'b1; start = 1'b1; we = 1'b0;
        step();
        ld_mar = 1'b0; start = 1'b0;
        check("ld_mar",    {16'h0, mar_a}, 32'h3010);
        check("ld_req1",   {31'h0, req_a}, 32'h1);
        check("ld_we",     {31'h0, we_a}, 32'h0);
        check("ld_busy",   {31'h0, busy_a}, 32'h1);
        step();
        check("ld_req2",   {31'h0, req_a}, 32'h1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("ld_done",   {31'h0, done_a}, 32'h1);
        check("ld_req_lo", {31'h0, req_a}, 32'h0);
        step();
        check("ld_done_1c", {31'h0, done_a}, 32'h0);
        check("ld_idle",    {31'h0, busy_a}, 32'h0);

        // Timeout with no ack: MAR preset to a known value first
        sel = 2'd3; reg_addr = 16'h1234; ld_mar = 1'b1;
        step();
        ld_mar = 1'b0;
        run_access(0, 1'b1, ra, da, ea, rb, db, eb, exp_flag);
        check("to_bound",  {31'h0, exp_flag}, 32'h0);
        check("to_req_a",  ra, 4);
        check("to_err_a",  ea, 1);
        check("to_done_a", da, 0);
        check("to_req_b",  rb, 15);
        check("to_err_b",  eb, 1);
        check("to_done_b", db, 0);
        check("to_mar",    {16'h0, mar_a}, 32'h1234);

        // Ack on the final allowed req cycle wins over the timeout
        run_access(4, 1'b0, ra, da, ea, rb, db, eb, exp_flag);
        check("ack4_bound", {31'h0, exp_flag}, 32'h0);
        check("ack4_req",   ra, 4);
        check("ack4_done",  da, 1);
        check("ack4_err",   ea, 0);

        // Ack on the first req cycle
        run_access(1, 1'b1, ra, da, ea, rb, db, eb, exp_flag);
        check("ack1_bound", {31'h0, exp_flag}, 32'h0);
        check("ack1_req",   ra, 1);
        check("ack1_done",  da, 1);

        // Ignored inputs during REQ and DONE, ack while IDLE
        start = 1'b1; we = 1'b1;
        step();
        check("ign_req", {31'h0, req_a}, 32'h1);
        sel = 2'd3; reg_addr = 16'hBEEF; ld_mar = 1'b1;
        step();
        check("ign_mar_req", {16'h0, mar_a}, 32'h1234);
        ld_mar = 1'b0; ack = 1'b1;
        step();
        ack = 1'b0;
        check("ign_done", {31'h0, done_a}, 32'h1);
        check("ign_mar_done", {16'h0, mar_a}, 32'h1234);
        step();
        start = 1'b0;
        check("ign_idle", {31'h0, busy_a}, 32'h0);
        step();
        check("ign_no_2nd_req",  {31'h0, req_a}, 32'h0);
        check("ign_no_2nd_busy", {31'h0, busy_a}, 32'h0);
        ack = 1'b1;
        step();
        check("idle_ack_done", {31'h0, done_a}, 32'h0);
        ack = 1'b0;
        step();
        check("idle_ack_busy", {31'h0, busy_a}, 32'h0);

        // Reset asserted between edges during REQ
        sel = 2'd1; offset_addr = 16'h5A5A; ld_mar = 1'b1; start = 1'b1; we = 1'b1;
        step();
        ld_mar = 1'b0; start = 1'b0;
        check("mr_req_pre", {31'h0, req_a}, 32'h1);
        check("mr_we_pre",  {31'h0, we_a}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_req", {31'h0, req_a}, 32'h0);
        check("mr_we",  {31'h0, we_a}, 32'h0);
        check("mr_mar", {16'h0, mar_a}, 32'h0);
        check("mr_busy", {31'h0, busy_a}, 32'h0);
        step();
        check("mr_done", {31'h0, done_a}, 32'h0);
        check("mr_err",  {31'h0, err_a}, 32'h0);
        rst_n = 1'b1;
        step();
        check("mr_post_done", {31'h0, done_a}, 32'h0);
        check("mr_post_err",  {31'h0, err_a}, 32'h0);
        run_access(2, 1'b0, ra, da, ea, rb, db, eb, exp_flag);
        check("mr_fresh_bound", {31'h0, exp_flag}, 32'h0);
        check("mr_fresh_req",   ra, 2);
        check("mr_fresh_done",  da, 1);
        check("mr_fresh_err",   ea, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lc3_mar_unit.md
Name: lc3_mar_unit

Overview:
Parametrised successor to the LC-3 MAR-path mux. It selects the memory address from four sources, with added zero-extension for TRAP vectors and a register passthrough. It registers the address into the MAR and runs a memory-access handshake with ack timeout detection. It sits between the datapath address adders/IR and the memory interface.

Parameters:
ADDR_W, 16, address/MAR width in bits
IMM_W, 8, IR immediate field width; legal range 1 <= IMM_W < ADDR_W
TIMEOUT, 15, maximum cycles spent in REQ waiting for ack before error; legal range 1 to 255

Ports:
i_clk  input  1  system clock, rising-edge
i_rst_n  input  1  asynchronous active-low reset
i_sel  input  2  source select: 0 SEXT(imm), 1 offset addr, 2 ZEXT(imm), 3 register addr
i_imm  input  IMM_W  IR immediate field (IR[IMM_W-1:0])
i_offset_addr  input  ADDR_W  base+offset adder result
i_reg_addr  input  ADDR_W  register-file operand used as address
i_ld_mar  input  1  load MAR with the selected source
i_start  input  1  begin a memory access at the MAR address
i_we  input  1  access type, sampled with i_start; 1 = write
i_mem_ack  input  1  memory completion
o_addr_next  output  ADDR_W  combinational selected address (pre-MAR)
o_mar  output  ADDR_W  MAR register contents
o_mem_req  output  1  memory request, held until ack or timeout
o_mem_we  output  1  registered access type, valid while o_mem_req=1
o_busy  output  1  high when not IDLE
o_done  output  1  one-cycle pulse on ack
o_err  output  1  one-cycle pulse on timeout

Behaviour:
- Reset, asynchronous on i_rst_n low:
  - o_mar=0, state=IDLE, timeout counter=0.
  - o_mem_req, o_mem_we, o_done and o_err are all 0.
- Source mux is combinational:
  - sel 0: imm sign-extended, replicating bit IMM_W-1.
  - sel 1: i_offset_addr.
  - sel 2: imm zero-extended.
  - sel 3: i_reg_addr.
- MAR load:
  - When i_ld_mar=1 and state=IDLE, o_mar <= o_addr_next at the clock edge.
  - i_ld_mar outside IDLE is ignored; the MAR stays stable during an access.
- FSM states are IDLE, REQ, DONE and ERR.
- IDLE:
  - i_start=1 -> REQ; o_mem_we <= i_we; counter <= 0.
  - If i_ld_mar and i_start are both high in the same cycle, the MAR loads and the access uses the new value.
  - o_mem_req rises the cycle after i_start, so latency from start to req is 1 cycle.
- REQ:
  - o_mem_req=1.
  - i_mem_ack=1 -> DONE.
  - Otherwise, if counter == TIMEOUT-1 -> ERR; else counter increments.
  - When ack arrives in the same cycle the timeout would fire, ack wins and the next state is DONE.
- DONE: o_done=1 for exactly one cycle, o_mem_req=0, then -> IDLE.
- ERR: o_err=1 for exactly one cycle, o_mem_req=0, then -> IDLE. The MAR is retained so the faulting address stays visible.
- In DONE and ERR, i_start and i_ld_mar are ignored. Accesses can therefore issue back-to-back every 3 cycles at minimum: start, req/ack, done.
- i_mem_ack outside REQ is ignored.
- i_start while in REQ, DONE or ERR is ignored; it is not queued.
- o_busy=1 in REQ, DONE and ERR.
- Reset asserted mid-access aborts immediately: o_mem_req drops asynchronously, and no o_done or o_err pulse is produced.
- TIMEOUT is the number of cycles o_mem_req stays high without ack. For example, TIMEOUT=15 gives 15 req cycles, then the ERR cycle.

Test Plan:
1. Mux, default params, imm=8'hF0: sel 0 -> 16'hFFF0; sel 2 -> 16'h00F0; sel 1 with offset 16'h3005 -> 16'h3005; sel 3 with reg 16'h4000 -> 16'h4000; imm=8'h7F, sel 0 -> 16'h007F.
2. Load and read:
   - Stimulus: ld_mar+start same cycle, sel 1, offset 16'h3010, we=0; ack on the 2nd req cycle.
   - Response: o_mar=16'h3010 next cycle; req high 2 cycles with we=0; done pulses 1 cycle; busy low after.
3. Timeout:
   - Stimulus: TIMEOUT=4, start, never ack.
   - Response: req high exactly 4 cycles, err pulses 1 cycle, no done, o_mar unchanged.
   - Also: ack on the 4th req cycle -> done, no err.
4. Ignored inputs: ld_mar with sel 3 and reg 16'hBEEF during REQ -> o_mar unchanged; start during REQ/DONE -> no second access; ack while IDLE -> no done.
5. Reset mid-REQ: assert i_rst_n=0 asynchronously between edges -> req/we/mar go to 0 immediately, no done/err; a fresh access after release works.
6. Parameter sweep ADDR_W=20, IMM_W=9: imm=9'h100, sel 0 -> 20'hFFF00; sel 2 -> 20'h00100.
